// File: rtl/bitwise_ops_monitor_if.sv
// ----------------------------------------------------------------------------
// bitwise_ops_monitor_if
// Sample stream from a bitwise-operations unit into its checker.
//   s_valid : sample valid (master -> slave)
//   s_ready : sample ready (slave -> master); a sample is taken when both are 1
//   s_in    : 4-bit operand vector that was applied to the unit
//   s_res   : 18-bit result vector of the unit, bit k-1 carries out_k
// ----------------------------------------------------------------------------
interface bitwise_ops_monitor_if;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  s_in;
    logic [17:0] s_res;

    modport master (output s_valid, output s_in, output s_res, input s_ready);
    modport slave  (input s_valid, input s_in, input s_res, output s_ready);
endinterface

// File: rtl/bitwise_ops_monitor.sv
// ----------------------------------------------------------------------------
// bitwise_ops_monitor
// Checks a run of NUM_VECTORS samples from a bitwise-operations unit against a
// locally computed expected vector, counts mismatches (saturating) and reports
// pass/fail at the end of the run.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : one-cycle pulse, begins a run from IDLE or DONE
//   smp       : sample stream (bitwise_ops_monitor_if.slave)
//   busy      : high in RUN and DRAIN
//   done      : one-cycle pulse on entry to DONE
//   pass      : in DONE, 1 when no mismatch was seen; 0 elsewhere
//   err_cnt   : saturating mismatch count of the current run
//   fail_in   : s_in of the first mismatching sample of the run
//   fail_res  : s_res of the first mismatching sample of the run
//
// Build option:
//   BITWISE_MON_CAPTURE_EN : when defined, fail_in/fail_res capture the first
//                            mismatching sample; otherwise they are tied to 0.
// ----------------------------------------------------------------------------
module bitwise_ops_monitor #(
    parameter int NUM_VECTORS = 16,
    parameter int ERR_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    bitwise_ops_monitor_if.slave  smp,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_cnt,
    output logic [3:0]            fail_in,
    output logic [17:0]           fail_res
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0]       LAST_IDX = 8'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

    // Reference model of the bitwise-operations unit; bit k-1 is out_k.
    function automatic logic [17:0] expected_vec(input logic [3:0] v);
        logic        a;
        logic        b;
        logic [17:0] r;
        a     = v[0];
        b     = v[1];
        r[0]  = a & b;
        r[1]  = a | b;
        r[2]  = ~(a & b);
        r[3]  = ~(a | b);
        r[4]  = a ^ b;
        r[5]  = ~(a ^ b);
        r[6]  = ~(a ^ b);
        r[7]  = ~a;
        r[8]  = a;
        r[9]  = a;
        r[10] = a;
        r[11] = !a;
        r[12] = !a;
        r[13] = a;
        r[14] = ~a;
        r[15] = ~a;
        r[16] = (|v[1:0]) && (|v[3:2]);
        r[17] = (|v[1:0]) || (|v[3:2]);
        return r;
    endfunction

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [7:0]       cnt_reg;
    logic             cmp_valid_reg;
    logic [3:0]       cmp_in_reg;
    logic [17:0]      cmp_res_reg;
    logic [ERR_W-1:0] err_cnt_reg;
    logic             done_reg;

    logic accept;
    logic start_ok;
    logic last_accept;
    logic mismatch;

    assign smp.s_ready = (state_reg == ST_RUN);
    assign accept      = smp.s_valid && (state_reg == ST_RUN);
    assign start_ok    = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign last_accept = accept && (cnt_reg == LAST_IDX);
    // Compare stage works on the registered copy of the accepted sample.
    assign mismatch    = cmp_valid_reg && (cmp_res_reg != expected_vec(cmp_in_reg));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start_ok) state_next = ST_RUN;
            ST_RUN:   if (last_accept) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE:  if (start_ok) state_next = ST_RUN;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 8'd0;
            cmp_valid_reg <= 1'b0;
            cmp_in_reg    <= 4'd0;
            cmp_res_reg   <= 18'd0;
            err_cnt_reg   <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            // DRAIN always moves to DONE, so having been in DRAIN marks DONE entry.
            done_reg      <= (state_reg == ST_DRAIN);
            cmp_valid_reg <= accept;
            if (accept) begin
                cmp_in_reg  <= smp.s_in;
                cmp_res_reg <= smp.s_res;
            end
            if (start_ok) begin
                cnt_reg     <= 8'd0;
                err_cnt_reg <= '0;
            end else begin
                if (accept) begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
                if (mismatch && (err_cnt_reg != ERR_MAX)) begin
                    err_cnt_reg <= err_cnt_reg + ERR_ONE;
                end
            end
        end
    end

    assign busy    = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign done    = done_reg;
    assign pass    = (state_reg == ST_DONE) && (err_cnt_reg == '0);
    assign err_cnt = err_cnt_reg;

`ifdef BITWISE_MON_CAPTURE_EN
    logic        fail_seen_reg;
    logic [3:0]  fail_in_reg;
    logic [17:0] fail_res_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_seen_reg <= 1'b0;
            fail_in_reg   <= 4'd0;
            fail_res_reg  <= 18'd0;
        end else if (start_ok) begin
            fail_seen_reg <= 1'b0;
            fail_in_reg   <= 4'd0;
            fail_res_reg  <= 18'd0;
        end else if (mismatch && !fail_seen_reg) begin
            fail_seen_reg <= 1'b1;
            fail_in_reg   <= cmp_in_reg;
            fail_res_reg  <= cmp_res_reg;
        end
    end

    assign fail_in  = fail_in_reg;
    assign fail_res = fail_res_reg;
`else
    assign fail_in  = 4'd0;
    assign fail_res = 18'd0;
`endif

endmodule

// File: tb/tb_bitwise_ops_monitor.sv
// ----------------------------------------------------------------------------
// tb_bitwise_ops_monitor
// Directed bench for bitwise_ops_monitor. A per-sample scoreboard holds the
// expected err_cnt after each accepted sample (checked one cycle after the
// accept); a per-run scoreboard holds the expected end-of-run results,
// checked on the done pulse. A second instance with ERR_W=2 sees the same
// sample stream to exercise saturation.
// ----------------------------------------------------------------------------
module tb_bitwise_ops_monitor;

    typedef struct {
        int          err;
        int          err2;
        logic [3:0]  fin;
        logic [17:0] fres;
    } run_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, pass;
    logic [7:0]  err_cnt;
    logic [3:0]  fail_in;
    logic [17:0] fail_res;
    logic        busy2, done2, pass2;
    logic [1:0]  err_cnt2;
    logic [3:0]  fail_in2;
    logic [17:0] fail_res2;

    bitwise_ops_monitor_if bus ();
    bitwise_ops_monitor_if bus2 ();

    assign bus2.s_valid = bus.s_valid;
    assign bus2.s_in    = bus.s_in;
    assign bus2.s_res   = bus.s_res;

    bitwise_ops_monitor #(.NUM_VECTORS(16), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .smp(bus.slave),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_in(fail_in), .fail_res(fail_res)
    );

    bitwise_ops_monitor #(.NUM_VECTORS(16), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .smp(bus2.slave),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
        .fail_in(fail_in2), .fail_res(fail_res2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int n_acc = 0;
    int last_acc_cyc = 0;
    int start_cyc = 0;
    logic acc_d1 = 1'b0;
    logic acc_d2 = 1'b0;
    int exp_q[$];
    run_exp_t run_q[$];
    int chk_e;

    // Run model
    int          m_err, m_err2;
    bit          m_seen;
    logic [3:0]  m_fin;
    logic [17:0] m_fres;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bit k-1 = out_k of the bitwise-operations unit.
    function automatic logic [17:0] tb_vec(input logic [3:0] v);
        logic a, b, lo, hi;
        logic [17:0] r;
        a = v[0]; b = v[1];
        lo = v[0] | v[1];
        hi = v[2] | v[3];
        r = '0;
        r[0]  = a & b;      r[1]  = a | b;
        r[2]  = ~(a & b);   r[3]  = ~(a | b);
        r[4]  = a ^ b;      r[5]  = a ~^ b;
        r[6]  = a ~^ b;     r[7]  = ~a;
        r[8]  = a;          r[9]  = a;
        r[10] = a;          r[11] = ~a;
        r[12] = ~a;         r[13] = a;
        r[14] = ~a;         r[15] = ~a;
        r[16] = lo & hi;    r[17] = lo | hi;
        return r;
    endfunction

    // Accept monitor: accepts are observed on the edge that takes them.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            acc_d1 <= 1'b0;
            acc_d2 <= 1'b0;
        end else begin
            acc_d1 <= bus.s_valid && bus.s_ready;
            acc_d2 <= acc_d1;
            if (bus.s_valid && bus.s_ready) begin
                n_acc        <= n_acc + 1;
                last_acc_cyc <= cyc + 1;
            end
        end
    end

    // err_cnt must reflect a sample one cycle after its accept.
    always @(negedge clk) begin
        if (rst_n && acc_d2) begin
            check("err_q_nonempty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                chk_e = exp_q.pop_front();
                check("err_step", 32'(err_cnt), chk_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_s_ready"}, 32'(bus.s_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 0);
        check({tag, "_fail_in"}, 32'(fail_in), 0);
        check({tag, "_fail_res"}, 32'(fail_res), 0);
    endtask

    task automatic run_begin();
        m_err = 0; m_err2 = 0; m_seen = 0; m_fin = '0; m_fres = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        check("start_busy", 32'(busy), 1);
        check("start_err_clr", 32'(err_cnt), 0);
        check("start_fail_in_clr", 32'(fail_in), 0);
        check("start_pass_low", 32'(pass), 0);
    endtask

    task automatic send(input logic [3:0] v, input logic [17:0] r);
        int guard = 0;
        bus.s_valid = 1'b1;
        bus.s_in    = v;
        bus.s_res   = r;
        if (r !== tb_vec(v)) begin
            if (m_err < 255) m_err++;
            if (m_err2 < 3) m_err2++;
            if (!m_seen) begin
                m_seen = 1; m_fin = v; m_fres = r;
            end
        end
        exp_q.push_back(m_err);
        while (bus.s_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("send_ready", 32'(bus.s_ready), 1);
        tick();
    endtask

    task automatic end_run();
        run_exp_t e;
        bit seen = 0;
        bus.s_valid = 1'b0;
        e.err = m_err; e.err2 = m_err2; e.fin = m_fin; e.fres = m_fres;
        run_q.push_back(e);
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        check("done_seen", 32'(seen), 1);
        if (seen) begin
            check("done_latency", cyc - last_acc_cyc, 1);
            check("run_q_size", run_q.size(), 1);
            if (run_q.size() > 0) begin
                e = run_q.pop_front();
                check("final_err", 32'(err_cnt), e.err);
                check("final_pass", 32'(pass), (e.err == 0) ? 1 : 0);
                check("final_err2", 32'(err_cnt2), e.err2);
                check("final_pass2", 32'(pass2), (e.err2 == 0) ? 1 : 0);
`ifdef BITWISE_MON_CAPTURE_EN
                check("fail_in", 32'(fail_in), 32'(e.fin));
                check("fail_res", 32'(fail_res), 32'(e.fres));
                check("fail_in2", 32'(fail_in2), 32'(e.fin));
`else
                check("fail_in_tied", 32'(fail_in), 0);
                check("fail_res_tied", 32'(fail_res), 0);
`endif
                @(negedge clk);
                check("done_pulse_end", 32'(done), 0);
                check("done_hold_pass", 32'(pass), (e.err == 0) ? 1 : 0);
                check("done_hold_err", 32'(err_cnt), e.err);
                check("done_s_ready", 32'(bus.s_ready), 0);
                check("done_busy", 32'(busy), 0);
            end
        end
        $display("[TB] run end: err_cnt=%0d pass=%0d err_cnt2=%0d fail_in=%0h fail_res=%0h",
                 err_cnt, pass, err_cnt2, fail_in, fail_res);
    endtask

    initial begin
        int acc0;
        int gaps;
        logic [3:0]  v;
        logic [17:0] r;
        rst_n = 1'b0; start = 1'b0;
        bus.s_valid = 1'b0; bus.s_in = '0; bus.s_res = '0;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Samples offered in IDLE are not taken.
        bus.s_valid = 1'b1; bus.s_in = 4'h3; bus.s_res = 18'h0;
        repeat (3) begin
            tick();
            check("idle_s_ready", 32'(bus.s_ready), 0);
        end
        check("idle_no_accept", n_acc, 0);
        check("idle_err", 32'(err_cnt), 0);
        bus.s_valid = 1'b0;

        // Run A: all correct, back-to-back.
        run_begin();
        for (int i = 0; i < 16; i++) send(4'(i), tb_vec(4'(i)));
        check("b2b_span", last_acc_cyc - start_cyc, 16);
        end_run();

        // Run B: s_in=3 carries bit0 flipped.
        run_begin();
        for (int i = 0; i < 16; i++)
            send(4'(i), (i == 3) ? (tb_vec(4'(i)) ^ 18'h00001) : tb_vec(4'(i)));
        end_run();

        // Run C: every sample corrupted (ERR_W=2 instance saturates at 3).
        run_begin();
        for (int i = 0; i < 16; i++) send(4'(15 - i), ~tb_vec(4'(15 - i)));
        end_run();

        // Run D: random valid gaps, start pulsed mid-run, two corrupted samples.
        run_begin();
        acc0 = n_acc;
        for (int i = 0; i < 16; i++) begin
            gaps = $urandom_range(0, 2);
            bus.s_valid = 1'b0;
            bus.s_in = 4'($urandom);
            repeat (gaps) tick();
            v = 4'($urandom);
            r = tb_vec(v);
            if (i == 2 || i == 9) r = r ^ (18'h1 << $urandom_range(0, 17));
            if (i == 5) start = 1'b1;
            send(v, r);
            start = 1'b0;
        end
        check("rand_accepts", n_acc - acc0, 16);
        end_run();
        bus.s_valid = 1'b1;
        repeat (3) begin
            tick();
            check("done_no_ready", 32'(bus.s_ready), 0);
        end
        check("done_no_accept", n_acc - acc0, 16);
        bus.s_valid = 1'b0;

        // Abort: reset after 7 corrupted accepts.
        run_begin();
        for (int i = 0; i < 7; i++) send(4'(i), ~tb_vec(4'(i)));
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("abort");
        repeat (2) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 0);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            check("post_rst_idle_busy", 32'(busy), 0);
            check("post_rst_idle_done", 32'(done), 0);
        end

        // Run E: fresh correct run after the abort.
        run_begin();
        for (int i = 0; i < 16; i++) send(4'(i), tb_vec(4'(i)));
        end_run();

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
